// File: rtl/bcd_ascii_tx_if.sv
// Byte-stream link from the BCD formatter toward the slow-control/UART byte sink.
// The master presents tx_data/tx_valid and the slave answers with tx_ready.
interface bcd_ascii_tx_if;
    localparam int unsigned BYTE_W = 8;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/bcd_ascii_tx.sv
// Captures each finished 4-digit BCD result and streams it as ASCII decimal bytes
// with optional leading-zero suppression/padding and a frame terminator.
module bcd_ascii_tx #(
    parameter logic       LZ_SUPPRESS = 1'b1,
    parameter logic       PAD_EN      = 1'b0,
    parameter logic [7:0] PAD_CHAR    = 8'h20,
    parameter logic       TERM_EN     = 1'b1,
    parameter logic [7:0] TERM_CHAR   = 8'h0D
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [15:0]         BCD_in,
    input  logic                conv_busy,
    bcd_ascii_tx_if.master      tx,
    output logic                frame_done,
    output logic [7:0]          drop_cnt,
    output logic                active
);
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, idx_dn;
    logic [BCD_W-1:0]   cur, cur_nxt;
    logic [BCD_W-1:0]   pend, pend_nxt;
    logic               pend_valid, pend_valid_nxt;
    logic               busy_d;
    logic [BYTE_W-1:0]  data_r, data_nxt;
    logic               valid_r, valid_nxt;
    logic               frame_done_nxt;
    logic [CNT_W-1:0]   drop_nxt;
    logic               active_nxt;
    logic               fall;
    logic               accept;
    logic               end_frame;
    logic               load;
    logic [BCD_W-1:0]   load_val;

    // Index of the most significant non-zero nibble; 0 when the value is all zeros.
    function automatic logic [IDX_W-1:0] msd_idx(input logic [BCD_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = '0;
        for (int i = 1; i < 4; i++) begin
            if (v[i*4 +: 4] != 4'd0) m = IDX_W'(i);
        end
        return m;
    endfunction

    // Skipping leading zeros jumps straight to the first significant digit.
    function automatic logic [IDX_W-1:0] first_idx(input logic [BCD_W-1:0] v);
        return (LZ_SUPPRESS && !PAD_EN) ? msd_idx(v) : IDX_W'(3);
    endfunction

    function automatic logic [BYTE_W-1:0] digit_char(input logic [BCD_W-1:0] v,
                                                     input logic [IDX_W-1:0] i);
        logic [3:0] nib;
        logic [BYTE_W-1:0] c;
        nib = v[{i, 2'b00} +: 4];
        if (LZ_SUPPRESS && (i > msd_idx(v))) c = PAD_CHAR;
        else if (nib <= 4'd9)                c = 8'h30 + {4'h0, nib};
        else                                 c = 8'h3F;
        return c;
    endfunction

    assign fall   = busy_d & ~conv_busy;
    assign accept = valid_r & tx.tx_ready;
    assign idx_dn = idx - IDX_W'(1);

    assign tx.tx_data  = data_r;
    assign tx.tx_valid = valid_r;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cur        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            busy_d     <= 1'b0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cur        <= cur_nxt;
            pend       <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            busy_d     <= conv_busy;
            data_r     <= data_nxt;
            valid_r    <= valid_nxt;
            frame_done <= frame_done_nxt;
            drop_cnt   <= drop_nxt;
            active     <= active_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cur_nxt        = cur;
        pend_nxt       = pend;
        pend_valid_nxt = pend_valid;
        data_nxt       = data_r;
        valid_nxt      = valid_r;
        frame_done_nxt = 1'b0;
        drop_nxt       = drop_cnt;
        end_frame      = 1'b0;
        load           = 1'b0;
        load_val       = BCD_in;

        case (state)
            IDLE: begin
                if (fall) load = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    if (idx != '0) begin
                        idx_nxt  = idx_dn;
                        data_nxt = digit_char(cur, idx_dn);
                    end else if (TERM_EN) begin
                        state_nxt = TERM;
                        data_nxt  = TERM_CHAR;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            TERM: begin
                if (accept) end_frame = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        // A result arriving on the last acceptance is kept, never counted as a drop.
        if (end_frame) begin
            frame_done_nxt = 1'b1;
            if (pend_valid) begin
                load           = 1'b1;
                load_val       = pend;
                pend_valid_nxt = fall;
                pend_nxt       = BCD_in;
            end else if (fall) begin
                load = 1'b1;
            end else begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        end else if (fall && (state != IDLE)) begin
            pend_nxt       = BCD_in;
            pend_valid_nxt = 1'b1;
            if (pend_valid && (drop_cnt != {CNT_W{1'b1}})) drop_nxt = drop_cnt + CNT_W'(1);
        end

        if (load) begin
            cur_nxt   = load_val;
            idx_nxt   = first_idx(load_val);
            state_nxt = SEND;
            valid_nxt = 1'b1;
            data_nxt  = digit_char(load_val, first_idx(load_val));
        end

        active_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Self-checking bench for bcd_ascii_tx: three parameter variants share one stimulus
// stream; accepted bytes are collected and compared with tables and a formatting model.
module tb_bcd_ascii_tx;
    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [15:0] bcd;
        logic [39:0] e0;
        logic [39:0] e1;
        logic [39:0] e2;
        int          n0;
        int          n1;
        int          n2;
        bit          lat1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic        busy;
    logic        ready_man;
    logic        ready_rand_en;
    logic        rnd_bit;
    logic        ready_drv;
    logic        fd0, fd1, fd2;
    logic [7:0]  dc0, dc1, dc2;
    logic        act0, act1, act2;

    int checks = 0;
    int errors = 0;
    int fdc[3];
    bit prev_stall[3];
    bit acc_prev[3];
    logic [7:0] prev_data[3];
    logic [7:0] last_acc[3];
    bq_t got0, got1, got2, exp0, exp1, exp2;
    vec_t tv[6];

    always #5 clk = ~clk;

    assign ready_drv = ready_rand_en ? rnd_bit : ready_man;

    bcd_ascii_tx_if if0();
    bcd_ascii_tx_if if1();
    bcd_ascii_tx_if if2();
    assign if0.tx_ready = ready_drv;
    assign if1.tx_ready = ready_drv;
    assign if2.tx_ready = ready_drv;

    bcd_ascii_tx u_def (
        .sys_clk(clk), .reset(rst), .BCD_in(bcd), .conv_busy(busy), .tx(if0),
        .frame_done(fd0), .drop_cnt(dc0), .active(act0));
    bcd_ascii_tx #(.PAD_EN(1'b1)) u_pad (
        .sys_clk(clk), .reset(rst), .BCD_in(bcd), .conv_busy(busy), .tx(if1),
        .frame_done(fd1), .drop_cnt(dc1), .active(act1));
    bcd_ascii_tx #(.LZ_SUPPRESS(1'b0)) u_nolz (
        .sys_clk(clk), .reset(rst), .BCD_in(bcd), .conv_busy(busy), .tx(if2),
        .frame_done(fd2), .drop_cnt(dc2), .active(act2));

    function automatic logic dut_valid(input int k);
        case (k) 0: return if0.tx_valid; 1: return if1.tx_valid; default: return if2.tx_valid; endcase
    endfunction
    function automatic logic [7:0] dut_data(input int k);
        case (k) 0: return if0.tx_data; 1: return if1.tx_data; default: return if2.tx_data; endcase
    endfunction
    function automatic logic dut_fd(input int k);
        case (k) 0: return fd0; 1: return fd1; default: return fd2; endcase
    endfunction
    function automatic logic [7:0] dut_drop(input int k);
        case (k) 0: return dc0; 1: return dc1; default: return dc2; endcase
    endfunction
    function automatic logic dut_act(input int k);
        case (k) 0: return act0; 1: return act1; default: return act2; endcase
    endfunction
    function automatic bq_t get_got(input int k);
        case (k) 0: return got0; 1: return got1; default: return got2; endcase
    endfunction
    function automatic bq_t get_exp(input int k);
        case (k) 0: return exp0; 1: return exp1; default: return exp2; endcase
    endfunction

    task automatic push_got(input int k, input logic [7:0] b);
        case (k) 0: got0.push_back(b); 1: got1.push_back(b); default: got2.push_back(b); endcase
    endtask
    task automatic push_exp(input int k, input logic [7:0] b);
        case (k) 0: exp0.push_back(b); 1: exp1.push_back(b); default: exp2.push_back(b); endcase
    endtask
    task automatic clear_all();
        got0.delete(); got1.delete(); got2.delete();
        exp0.delete(); exp1.delete(); exp2.delete();
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // Reference formatter: dut0 = suppress/skip, dut1 = suppress/pad, dut2 = no suppression.
    task automatic model_frame(input int k, input logic [15:0] v);
        bit lz, pad, seen, lead;
        logic [3:0] n;
        lz = (k != 2);
        pad = (k == 1);
        seen = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            n = v[i*4 +: 4];
            lead = !seen && (n == 4'd0) && (i > 0);
            if (n != 4'd0) seen = 1'b1;
            if (lead && lz) begin
                if (pad) push_exp(k, 8'h20);
            end else begin
                push_exp(k, (n <= 4'd9) ? (8'h30 + 8'(n)) : 8'h3F);
            end
        end
        push_exp(k, 8'h0D);
    endtask
    task automatic model_all(input logic [15:0] v);
        for (int k = 0; k < 3; k++) model_frame(k, v);
    endtask

    task automatic cmp_stream(input string name, input int k);
        bq_t g, e;
        g = get_got(k);
        e = get_exp(k);
        chk({name, "_len"}, k, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            chk({name, "_byte"}, k, 32'(g[i]), 32'(e[i]));
    endtask

    task automatic zero_chk(input string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_valid"}, k, 32'(dut_valid(k)), 0);
            chk({name, "_data"}, k, 32'(dut_data(k)), 0);
            chk({name, "_frame_done"}, k, 32'(dut_fd(k)), 0);
            chk({name, "_drop"}, k, 32'(dut_drop(k)), 0);
            chk({name, "_active"}, k, 32'(dut_act(k)), 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Busy high for one cycle, then low with the result: returns inside the fall cycle.
    task automatic fall(input logic [15:0] v);
        step();
        busy = 1'b1;
        bcd = 16'($urandom);
        step();
        busy = 1'b0;
        bcd = v;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (!act0 && !act1 && !act2 && !if0.tx_valid && !if1.tx_valid && !if2.tx_valid) quiet++;
            else quiet = 0;
        end
        chk({name, "_idle_timeout"}, 0, 32'(quiet >= 3), 1);
        step();
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int unsigned r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 5);
            if (r < 2)       v[i*4 +: 4] = 4'd0;
            else if (r == 2) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else             v[i*4 +: 4] = 4'($urandom_range(1, 9));
        end
        return v;
    endfunction

    task automatic sample(input int k);
        logic v, r;
        logic [7:0] d;
        v = dut_valid(k);
        r = ready_drv;
        d = dut_data(k);
        if (rst) begin
            prev_stall[k] = 1'b0;
            acc_prev[k] = 1'b0;
            return;
        end
        if (prev_stall[k]) chk("hold_while_stalled", k, {23'b0, v, d}, {23'b0, 1'b1, prev_data[k]});
        if (dut_fd(k)) begin
            fdc[k]++;
            chk("frame_done_after_term", k, {23'b0, acc_prev[k], last_acc[k]}, {23'b0, 1'b1, 8'h0D});
        end
        if (v && r) begin
            push_got(k, d);
            last_acc[k] = d;
            acc_prev[k] = 1'b1;
        end else begin
            acc_prev[k] = 1'b0;
        end
        prev_stall[k] = v && !r;
        prev_data[k] = d;
    endtask

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) sample(k);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last_v;
        logic [39:0] e;
        int n;
        int nfr;
        int fd_snap[3];

        tv[0] = '{bcd: 16'h0042, e0: 40'h34320D0000, e1: 40'h202034320D, e2: 40'h303034320D, n0: 3, n1: 5, n2: 5, lat1: 1'b1};
        tv[1] = '{bcd: 16'h0000, e0: 40'h300D000000, e1: 40'h202020300D, e2: 40'h303030300D, n0: 2, n1: 5, n2: 5, lat1: 1'b0};
        tv[2] = '{bcd: 16'h10A3, e0: 40'h31303F330D, e1: 40'h31303F330D, e2: 40'h31303F330D, n0: 5, n1: 5, n2: 5, lat1: 1'b1};
        tv[3] = '{bcd: 16'h9999, e0: 40'h393939390D, e1: 40'h393939390D, e2: 40'h393939390D, n0: 5, n1: 5, n2: 5, lat1: 1'b1};
        tv[4] = '{bcd: 16'h0A00, e0: 40'h3F30300D00, e1: 40'h203F30300D, e2: 40'h303F30300D, n0: 4, n1: 5, n2: 5, lat1: 1'b0};
        tv[5] = '{bcd: 16'h0005, e0: 40'h350D000000, e1: 40'h202020350D, e2: 40'h303030350D, n0: 2, n1: 5, n2: 5, lat1: 1'b0};

        rst = 1'b1;
        busy = 1'b0;
        bcd = 16'h0000;
        ready_man = 1'b1;
        ready_rand_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fdc[k] = 0; prev_stall[k] = 0; acc_prev[k] = 0; prev_data[k] = 0; last_acc[k] = 0;
        end
        #12;
        zero_chk("reset_state");
        step();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("no_false_edge_valid", k, 32'(dut_valid(k)), 0);
        end

        // Table vectors with tx_ready held high.
        for (int t = 0; t < 6; t++) begin
            clear_all();
            for (int k = 0; k < 3; k++) fd_snap[k] = fdc[k];
            fall(tv[t].bcd);
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("valid_in_fall_cycle", k, 32'(dut_valid(k)), 0);
            @(negedge clk);
            bcd = 16'($urandom);
            for (int k = 0; k < 3; k++) begin
                case (k) 0: e = tv[t].e0; 1: e = tv[t].e1; default: e = tv[t].e2; endcase
                chk("active_in_frame", k, 32'(dut_act(k)), 1);
                if (k != 0 || tv[t].lat1) begin
                    chk("first_byte_latency_valid", k, 32'(dut_valid(k)), 1);
                    chk("first_byte_latency_data", k, 32'(dut_data(k)), 32'(e[39:32]));
                end
            end
            wait_idle("table");
            for (int k = 0; k < 3; k++) begin
                case (k) 0: begin e = tv[t].e0; n = tv[t].n0; end
                         1: begin e = tv[t].e1; n = tv[t].n1; end
                         default: begin e = tv[t].e2; n = tv[t].n2; end
                endcase
                for (int j = 0; j < n; j++) push_exp(k, e[39-8*j -: 8]);
                cmp_stream("table_stream", k);
                chk("table_frame_count", k, 32'(fdc[k] - fd_snap[k]), 1);
            end
        end

        // Stall pattern 1-0-0-1 on a full-width value.
        clear_all();
        fall(16'h9999);
        for (int c = 0; c < 30; c++) begin
            ready_man = (c % 4 == 0) || (c % 4 == 3);
            step();
        end
        ready_man = 1'b1;
        wait_idle("stall");
        model_all(16'h9999);
        for (int k = 0; k < 3; k++) cmp_stream("stall_stream", k);

        // Falls while stalled: the middle result is overwritten.
        clear_all();
        ready_man = 1'b0;
        fall(16'h1234);
        fall(16'h0005);
        fall(16'h0777);
        repeat (3) step();
        ready_man = 1'b1;
        wait_idle("overwrite");
        model_all(16'h1234);
        model_all(16'h0777);
        for (int k = 0; k < 3; k++) begin
            cmp_stream("overwrite_stream", k);
            chk("overwrite_drop_cnt", k, 32'(dut_drop(k)), 1);
        end

        // Reset after two bytes, with a pending result queued.
        clear_all();
        ready_man = 1'b0;
        fall(16'h1234);
        fall(16'h0005);
        ready_man = 1'b1;
        step();
        step();
        ready_man = 1'b0;
        rst = 1'b1;
        #1;
        zero_chk("reset_mid_frame");
        step();
        step();
        rst = 1'b0;
        ready_man = 1'b1;
        repeat (10) step();
        for (int k = 0; k < 3; k++) begin
            push_exp(k, 8'h31);
            push_exp(k, 8'h32);
            chk("reset_no_resume_len", k, 32'(get_got(k).size()), 2);
        end
        fall(16'h0042);
        wait_idle("post_reset");
        model_all(16'h0042);
        for (int k = 0; k < 3; k++) cmp_stream("post_reset_stream", k);

        // Randomized values and sink back-pressure against the model.
        clear_all();
        for (int k = 0; k < 3; k++) fd_snap[k] = fdc[k];
        nfr = 0;
        ready_rand_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            last_v = rand_bcd();
            fall(last_v);
            model_all(last_v);
            nfr++;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 4)) step();
                last_v = rand_bcd();
                fall(last_v);
                model_all(last_v);
                nfr++;
            end
            wait_idle("random");
        end
        ready_rand_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp_stream("random_stream", k);
            chk("random_frame_count", k, 32'(fdc[k] - fd_snap[k]), 32'(nfr));
            chk("random_drop_cnt", k, 32'(dut_drop(k)), 0);
        end

        // Drop counter saturation.
        clear_all();
        ready_man = 1'b0;
        fall(16'h0001);
        model_all(16'h0001);
        last_v = 16'h0000;
        for (int i = 0; i < 257; i++) begin
            last_v = rand_bcd();
            fall(last_v);
        end
        model_all(last_v);
        step();
        ready_man = 1'b1;
        wait_idle("saturate");
        for (int k = 0; k < 3; k++) begin
            chk("drop_cnt_saturated", k, 32'(dut_drop(k)), 255);
            cmp_stream("saturate_stream", k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
